// File: rtl/dcache_ctrl_if.sv
// CPU data port and main-memory port of the data cache.
// The cache uses the slave view; the CPU/memory side uses the master view.
interface dcache_ctrl_if;
    logic        cpu_read_i;
    logic        cpu_write_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  cpu_read_i,
        input  cpu_write_i,
        input  cpu_addr_i,
        input  cpu_wdata_i,
        output cpu_rdata_o,
        output cpu_stall_o,
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport master (
        output cpu_read_i,
        output cpu_write_i,
        output cpu_addr_i,
        output cpu_wdata_i,
        input  cpu_rdata_o,
        input  cpu_stall_o,
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// 4-word lines refilled word by word over a handshaked memory port.
module dcache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dcache_ctrl_if.slave bus,
    output logic [31:0]  hit_count_o,
    output logic [31:0]  miss_count_o
);
    localparam int NLINES   = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE,
        S_WDONE
    } state_t;

    state_t                r_state;
    logic [NLINES-1:0]     r_valid;
    logic [TAG_BITS-1:0]   r_tag  [NLINES];
    logic [31:0]           r_data [NLINES][4];
    logic [1:0]            r_cnt;
    logic                  r_just_refilled;
    logic [INDEX_BITS-1:0] r_ref_idx;
    logic [TAG_BITS-1:0]   r_ref_tag;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [31:0]           r_hits;
    logic [31:0]           r_misses;

    logic [1:0]            w_off;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic [31:0]           w_word;
    logic                  w_ack;
    logic                  w_stall;
    logic                  w_unused_addr;

    assign w_off  = bus.cpu_addr_i[3:2];
    assign w_idx  = bus.cpu_addr_i[INDEX_BITS+3:4];
    assign w_tag  = bus.cpu_addr_i[31:INDEX_BITS+4];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word = r_data[w_idx][w_off];
    // An ack only counts while a transaction is actually outstanding.
    assign w_ack  = bus.mem_ack_i & r_mem_req;
    assign w_unused_addr = ^bus.cpu_addr_i[1:0];

    // Stall decode: only an IDLE hit or the WDONE cycle lets the CPU go.
    always_comb begin
        w_stall = 1'b0;
        unique case (r_state)
            S_IDLE:   w_stall = (bus.cpu_read_i & ~w_hit) | bus.cpu_write_i;
            S_REFILL: w_stall = 1'b1;
            S_WRITE:  w_stall = 1'b1;
            S_WDONE:  w_stall = 1'b0;
            default:  w_stall = 1'b0;
        endcase
    end

    assign bus.cpu_stall_o = w_stall;
    assign bus.cpu_rdata_o = (bus.cpu_read_i && w_hit) ? w_word : 32'h0;
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;
    assign hit_count_o     = r_hits;
    assign miss_count_o    = r_misses;

    // Control FSM, valid bits, memory request registers and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_valid         <= '0;
            r_cnt           <= 2'd0;
            r_just_refilled <= 1'b0;
            r_ref_idx       <= '0;
            r_ref_tag       <= '0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= 32'h0;
            r_mem_wdata     <= 32'h0;
            r_hits          <= 32'h0;
            r_misses        <= 32'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_just_refilled <= 1'b0;
                    if (bus.cpu_write_i) begin
                        r_state     <= S_WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {bus.cpu_addr_i[31:2], 2'b00};
                        r_mem_wdata <= bus.cpu_wdata_i;
                    end else if (bus.cpu_read_i && !w_hit) begin
                        r_state        <= S_REFILL;
                        r_cnt          <= 2'd0;
                        r_mem_req      <= 1'b1;
                        r_mem_we       <= 1'b0;
                        r_mem_addr     <= {bus.cpu_addr_i[31:4], 4'b0000};
                        r_valid[w_idx] <= 1'b0;
                        r_ref_idx      <= w_idx;
                        r_ref_tag      <= w_tag;
                        r_misses       <= r_misses + 32'd1;
                    end else if (bus.cpu_read_i && !r_just_refilled) begin
                        r_hits <= r_hits + 32'd1;
                    end
                end
                S_REFILL: begin
                    if (w_ack) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_valid[r_ref_idx] <= 1'b1;
                            r_mem_req          <= 1'b0;
                            r_just_refilled    <= 1'b1;
                            r_state            <= S_IDLE;
                        end else begin
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_WDONE;
                    end
                end
                S_WDONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays: refill fill-in and write-through hit update.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (r_state == S_REFILL && w_ack) begin
                r_data[r_ref_idx][r_cnt] <= bus.mem_rdata_i;
                if (r_cnt == 2'd3) begin
                    r_tag[r_ref_idx] <= r_ref_tag;
                end
            end
            if (r_state == S_WRITE && w_ack && w_hit) begin
                r_data[w_idx][w_off] <= bus.cpu_wdata_i;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: vector table of CPU operations
// against a latency-programmable memory model, plus a mid-refill reset.
module tb_dcache_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.INDEX_BITS(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          stalls;
        logic [31:0] rdata;
        logic [31:0] hits;
        logic [31:0] misses;
        int          nrd;
        int          nwr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int lat = 2;
    bit model_en = 1'b1;

    logic [31:0] wmem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic        log_we   [$];
    logic [31:0] log_wd   [$];

    vec_t tbl [14];
    vec_t post [2];

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return 32'hC0DE0000 | {16'h0, a[15:0]};
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr,
                                input logic [31:0] addr,
                                input logic [31:0] wdata,
                                input int lt, input int st,
                                input logic [31:0] rdata,
                                input logic [31:0] h,
                                input logic [31:0] m,
                                input int nrd, input int nwr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.lat = lt; v.stalls = st; v.rdata = rdata;
        v.hits = h; v.misses = m; v.nrd = nrd; v.nwr = nwr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    // Memory model: ack lat cycles after each request (or previous ack).
    initial begin : mem_model
        int cnt;
        cnt = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk_i);
            if (!model_en) begin
                cnt = 0;
            end else begin
                if (bus.mem_ack_i) begin
                    bus.mem_ack_i = 1'b0;
                    cnt = 0;
                end
                if (rst_i || bus.mem_req_o !== 1'b1) begin
                    cnt = 0;
                end else begin
                    cnt++;
                    if (cnt >= lat) begin
                        cnt = 0;
                        bus.mem_ack_i = 1'b1;
                        log_addr.push_back(bus.mem_addr_o);
                        log_we.push_back(bus.mem_we_o);
                        log_wd.push_back(bus.mem_wdata_o);
                        if (bus.mem_we_o) begin
                            wmem[bus.mem_addr_o] = bus.mem_wdata_o;
                            bus.mem_rdata_i = 32'h0;
                        end else begin
                            bus.mem_rdata_i = memf(bus.mem_addr_o);
                        end
                    end
                end
            end
        end
    end

    // Request fields must hold while a transaction waits for its ack.
    initial begin : hs_mon
        logic        p_req;
        logic        p_ack;
        logic        p_rst;
        logic        p_we;
        logic [31:0] p_addr;
        logic [31:0] p_wd;
        bit          p_ok;
        p_ok = 1'b0;
        p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b1; p_we = 1'b0;
        p_addr = 32'h0; p_wd = 32'h0;
        forever begin
            @(negedge clk_i);
            #4;
            if (p_ok && p_req === 1'b1 && !p_ack && !p_rst) begin
                chk("hs_req", {31'h0, bus.mem_req_o}, 32'h1);
                chk("hs_we", {31'h0, bus.mem_we_o}, {31'h0, p_we});
                chk("hs_addr", bus.mem_addr_o, p_addr);
                chk("hs_wdata", bus.mem_wdata_o, p_wd);
            end
            p_ok   = 1'b1;
            p_req  = bus.mem_req_o;
            p_ack  = bus.mem_ack_i;
            p_rst  = rst_i;
            p_we   = bus.mem_we_o;
            p_addr = bus.mem_addr_o;
            p_wd   = bus.mem_wdata_o;
        end
    end

    task automatic do_op(input vec_t v, input string tg);
        int          st;
        int          nr;
        int          nw;
        logic [31:0] rd;
        logic [31:0] ea;
        @(negedge clk_i);
        #2;
        lat = v.lat;
        log_addr.delete();
        log_we.delete();
        log_wd.delete();
        bus.cpu_read_i  = v.rd;
        bus.cpu_write_i = v.wr;
        bus.cpu_addr_i  = v.addr;
        bus.cpu_wdata_i = v.wdata;
        st = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (bus.cpu_stall_o === 1'b0) break;
            st++;
            @(negedge clk_i);
            #2;
        end
        rd = bus.cpu_rdata_o;
        @(posedge clk_i);
        #1;
        nr = 0;
        nw = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_we[i]) nw++;
            else nr++;
        end
        chk({tg, "_stall"}, 32'(st), 32'(v.stalls));
        chk({tg, "_rdata"}, rd, v.rdata);
        chk({tg, "_hits"}, hit_count_o, v.hits);
        chk({tg, "_misses"}, miss_count_o, v.misses);
        chk({tg, "_nrd"}, 32'(nr), 32'(v.nrd));
        chk({tg, "_nwr"}, 32'(nw), 32'(v.nwr));
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_we[i]) begin
                ea = {v.addr[31:2], 2'b00};
                chk({tg, "_wdata"}, log_wd[i], v.wdata);
            end else begin
                ea = {v.addr[31:4], 4'b0000} + 32'(4 * i);
            end
            chk({tg, "_maddr"}, log_addr[i], ea);
        end
    endtask

    initial begin : main
        int n;
        bus.cpu_read_i  = 1'b0;
        bus.cpu_write_i = 1'b0;
        bus.cpu_addr_i  = 32'h0;
        bus.cpu_wdata_i = 32'h0;

        tbl[0]  = mk(1, 0, 32'h40, 0, 2, 9, 32'hC0DE0040, 0, 1, 4, 0);
        tbl[1]  = mk(1, 0, 32'h44, 0, 2, 0, 32'hC0DE0044, 1, 1, 0, 0);
        tbl[2]  = mk(0, 1, 32'h48, 32'hDEADBEEF, 2, 3, 0, 1, 1, 0, 1);
        tbl[3]  = mk(1, 0, 32'h48, 0, 2, 0, 32'hDEADBEEF, 2, 1, 0, 0);
        tbl[4]  = mk(0, 1, 32'h1000, 32'h12345678, 2, 3, 0, 2, 1, 0, 1);
        tbl[5]  = mk(1, 0, 32'h1000, 0, 2, 9, 32'h12345678, 2, 2, 4, 0);
        tbl[6]  = mk(1, 0, 32'h80, 0, 2, 9, 32'hC0DE0080, 2, 3, 4, 0);
        tbl[7]  = mk(1, 0, 32'h180, 0, 2, 9, 32'hC0DE0180, 2, 4, 4, 0);
        tbl[8]  = mk(1, 0, 32'h80, 0, 2, 9, 32'hC0DE0080, 2, 5, 4, 0);
        tbl[9]  = mk(1, 0, 32'h8C, 0, 1, 0, 32'hC0DE008C, 3, 5, 0, 0);
        tbl[10] = mk(1, 0, 32'h234, 0, 1, 5, 32'hC0DE0234, 3, 6, 4, 0);
        tbl[11] = mk(0, 1, 32'h44, 32'hCAFEF00D, 3, 4, 0, 3, 6, 0, 1);
        tbl[12] = mk(1, 0, 32'h44, 0, 1, 0, 32'hCAFEF00D, 4, 6, 0, 0);
        tbl[13] = mk(1, 0, 32'h1008, 0, 1, 0, 32'hC0DE1008, 5, 6, 0, 0);

        post[0] = mk(1, 0, 32'h40, 0, 2, 9, 32'hC0DE0040, 0, 1, 4, 0);
        post[1] = mk(1, 0, 32'h44, 0, 2, 0, 32'hCAFEF00D, 1, 1, 0, 0);

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("rst_we", {31'h0, bus.mem_we_o}, 32'h0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_stall", {31'h0, bus.cpu_stall_o}, 32'h0);
        chk("rst_hits", hit_count_o, 32'h0);
        chk("rst_misses", miss_count_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i], $sformatf("v%0d", i));
        end

        // Reset while the second refill word is outstanding.
        @(negedge clk_i);
        #2;
        lat = 2;
        log_addr.delete();
        log_we.delete();
        log_wd.delete();
        bus.cpu_write_i = 1'b0;
        bus.cpu_read_i  = 1'b1;
        bus.cpu_addr_i  = 32'h300;
        n = 0;
        while (log_addr.size() < 1 && n < 100) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        chk("mid_word0", 32'(log_addr.size()), 32'h1);
        @(negedge clk_i);
        #2;
        chk("mid_req_before", {31'h0, bus.mem_req_o}, 32'h1);
        rst_i = 1'b1;
        model_en = 1'b0;
        bus.mem_ack_i = 1'b0;
        bus.cpu_read_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("mid_rst_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("mid_rst_addr", bus.mem_addr_o, 32'h0);
        chk("mid_rst_stall", {31'h0, bus.cpu_stall_o}, 32'h0);
        chk("mid_rst_hits", hit_count_o, 32'h0);
        chk("mid_rst_misses", miss_count_o, 32'h0);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        bus.mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("late_ack_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("late_ack_stall", {31'h0, bus.cpu_stall_o}, 32'h0);
        @(negedge clk_i);
        #2;
        bus.mem_ack_i = 1'b0;
        model_en = 1'b1;

        for (int i = 0; i < 2; i++) begin
            do_op(post[i], $sformatf("post%0d", i));
        end

        @(negedge clk_i);
        bus.cpu_read_i  = 1'b0;
        bus.cpu_write_i = 1'b0;
        repeat (2) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache that sits between the single-cycle CPU's data port and a slower word-wide main memory. It answers the CPU's load/store requests, giving a combinational hit path and a stall signal, and issues handshaked single-word transactions to main memory. On a read miss it refills a 4-word line. Read hit and miss counters are exposed for the cache-simulation benches.

## Interface
- INDEX_BITS, 4, line index width (2^INDEX_BITS lines of 4 × 32-bit words)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- cpu_read_i  in  1  load request (level, held by CPU while stalled)
- cpu_write_i  in  1  store request (level, held while stalled)
- cpu_addr_i  in  32  byte address; [1:0] ignored
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data (combinational)
- cpu_stall_o  out  1  CPU must hold PC/request this cycle (combinational)
- mem_req_o  out  1  memory transaction valid (registered)
- mem_we_o  out  1  1 = write, 0 = read (registered)
- mem_addr_o  out  32  word-aligned memory address (registered)
- mem_wdata_o  out  32  write data (registered)
- mem_ack_i  in  1  transaction in flight completes at this edge
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- hit_count_o  out  32  read hits since reset
- miss_count_o  out  32  read misses since reset

## Operation
- Address split: offset = addr[3:2], index = addr[INDEX_BITS+3:4], tag = addr[31:INDEX_BITS+4].
- Storage per line: valid bit, tag, 4 data words. Hit = valid[index] and tag match.
- If both cpu_write_i and cpu_read_i are asserted, the write takes priority. The bench must not drive this combination.
- FSM states: IDLE, REFILL, WRITE, WDONE.
- **IDLE**
  - Read hit: cpu_rdata_o = the hit word. Stall stays 0.
  - Read miss: the FSM moves to REFILL. Actions on that edge:
    - word counter = 0
    - mem_req_o = 1, mem_we_o = 0
    - mem_addr_o = {tag, index, 2'b00, 2'b00}
    - valid[index] is cleared
  - Write: the FSM moves to WRITE. Actions on that edge: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {addr[31:2], 2'b00}, mem_wdata_o = cpu_wdata_i.
- **REFILL**
  - Each mem_ack_i edge stores mem_rdata_i into word[counter] and increments the counter.
  - After acks for words 0–2, mem_addr_o advances by 4 and mem_req_o stays 1.
  - The ack for word 3 does the following, then the FSM returns to IDLE:
    - sets the valid bit and tag
    - drops mem_req_o
  - Back in IDLE the held read now hits.
- **WRITE**
  - The FSM waits for mem_ack_i.
  - On the ack edge: if the line hits, cpu_wdata_i is written into the cached word. On a miss the cache is not allocated.
  - mem_req_o and mem_we_o drop, and the FSM moves to WDONE.
- **WDONE**
  - Lasts one cycle with stall = 0, so the CPU retires the store, then the FSM returns to IDLE.
- **Stall (combinational)**
  - IDLE: (cpu_read_i & miss) | cpu_write_i
  - REFILL and WRITE: 1
  - WDONE: 0
- **cpu_rdata_o**: the hit word when cpu_read_i and hit, otherwise 0.
- **Counters**
  - miss_count_o increments on the IDLE→REFILL edge.
  - hit_count_o increments on an IDLE read-hit edge, except the first IDLE cycle after a refill. A just_refilled flag suppresses that cycle, so a miss is not also counted as a hit.
  - Both counters wrap modulo 2^32.

## Timing
- Reset, and reset mid-operation, produce:
  - FSM in IDLE
  - all valid bits cleared
  - counters cleared
  - just_refilled = 0
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0
  - In-flight transactions are abandoned and a late mem_ack_i is ignored. Data and tag arrays are not cleared.
- Memory handshake:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable while mem_req_o = 1 until the mem_ack_i edge.
  - mem_ack_i while mem_req_o = 0 is ignored.
  - The next refill word is requested in the cycle after an ack (back-to-back).
- Read hit latency: 0 cycles, no stall.
- Read miss with fixed ack latency L (ack L cycles after request): stall lasts 1 + 4L cycles, then the hit is served.
- Store with ack latency L: stall lasts 1 + L cycles, then one WDONE cycle.
- cpu_addr_i and cpu_wdata_i are sampled while stalled. The CPU holds them constant.

## Test plan
- Reset, then read 0x0000_0040 with memory ack 2 cycles after each request:
  - 4 memory reads at 0x40, 0x44, 0x48, 0x4C
  - stall lasts 9 cycles, then data = mem[0x40]
  - miss_count = 1, hit_count = 0
- Read 0x44 after that refill:
  - zero stall, data = mem[0x44]
  - hit_count = 1
- Store 0xDEADBEEF to 0x48 (line resident), then read 0x48:
  - one memory write with we = 1 at 0x48
  - the read hits and returns 0xDEADBEEF
- Store to 0x1000 (not resident), then read 0x1000:
  - the store makes a memory write only, with no refill
  - the read misses (miss_count increments)
- Conflict: read 0x40, then read 0x40 + (16 << 4) (same index, different tag), then read 0x40 again:
  - three misses, with the line evicted each time
- Assert rst_i during the second refill word:
  - next cycle: mem_req_o = 0, stall = 0 with no request
  - counters = 0, and a read of 0x40 misses again
